pc_sequencer: RTL and testbench

- Owns the fetch PC/nPC pair for the delayed-branch MIPS pipeline.
- Sequences the +4 increment and the branch/jump target load.
- Tracks the delay slot, annuls it for branch-likely not-taken, and vectors to an exception address on a misaligned target.
- Sits between the ID-stage branch/jump resolution and instruction-memory addressing. Feeds pc to IF and pc_plus8 to the link-register path.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC/nPC pair for a delayed-branch MIPS pipeline.
// Handles +4 sequencing, delayed branch/jump redirects, branch-likely
// annulment of the delay slot, and trapping of misaligned redirect targets.
module pc_sequencer #(
  parameter int PC_W       = 9,
  parameter int RESET_PC   = 0,
  parameter int EXC_VECTOR = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  input  logic            annul_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic [PC_W-1:0] pc_plus8,
  output logic            in_slot,
  output logic            squash,
  output logic            addr_err
);

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] STEP4      = PC_W'(4);
  localparam logic [PC_W-1:0] STEP8      = PC_W'(8);
  localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] EXC_ADDR   = PC_W'(EXC_VECTOR);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            in_slot_q, in_slot_d;
  logic            squash_q, squash_d;
  logic            addr_err_q, addr_err_d;
  logic            misaligned;

  assign misaligned = (target[1:0] != 2'b00);

  // Next-state selection; a stall holds every register, which also stretches addr_err.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    in_slot_d  = in_slot_q;
    squash_d   = squash_q;
    addr_err_d = addr_err_q;
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (redirect && misaligned) begin
            pc_d       = EXC_ADDR;
            npc_d      = EXC_ADDR + STEP4;
            addr_err_d = 1'b1;
            squash_d   = 1'b1;
            in_slot_d  = 1'b0;
            state_d    = RUN;
          end else if (redirect) begin
            pc_d       = npc_q;
            npc_d      = target;
            in_slot_d  = 1'b1;
            squash_d   = 1'b0;
            addr_err_d = 1'b0;
            state_d    = SLOT;
          end else if (annul_req) begin
            pc_d       = npc_q;
            npc_d      = npc_q + STEP4;
            squash_d   = 1'b1;
            in_slot_d  = 1'b1;
            addr_err_d = 1'b0;
            state_d    = RUN;
          end else begin
            pc_d       = npc_q;
            npc_d      = npc_q + STEP4;
            in_slot_d  = 1'b0;
            squash_d   = 1'b0;
            addr_err_d = 1'b0;
            state_d    = RUN;
          end
        end
        SLOT: begin
          // A branch sitting in a delay slot is dropped, so redirect/annul are ignored here.
          pc_d       = npc_q;
          npc_d      = npc_q + STEP4;
          in_slot_d  = 1'b0;
          squash_d   = 1'b0;
          addr_err_d = 1'b0;
          state_d    = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_ADDR;
      npc_q      <= RESET_ADDR + STEP4;
      in_slot_q  <= 1'b0;
      squash_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      in_slot_q  <= in_slot_d;
      squash_q   <= squash_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign npc      = npc_q;
  assign pc_plus8 = pc_q + STEP8;
  assign in_slot  = in_slot_q;
  assign squash   = squash_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a behavioural reference model
// feeding a scoreboard queue, plus constant checks at key points.
module tb_pc_sequencer;

  localparam int PC_W = 9;
  localparam int MOD  = 512;

  logic            clk;
  logic            reset_n;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] target;
  logic            annul_req;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] pc_plus8;
  logic            in_slot;
  logic            squash;
  logic            addr_err;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] p8;
    logic            in_slot;
    logic            squash;
    logic            addr_err;
  } exp_t;

  exp_t sb[$];

  int checks;
  int errors;

  // Reference model state
  int m_pc, m_npc;
  bit m_in_delay, m_in_slot, m_squash, m_addr_err;

  pc_sequencer #(
    .PC_W(PC_W),
    .RESET_PC(0),
    .EXC_VECTOR(256)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .redirect(redirect),
    .target(target),
    .annul_req(annul_req),
    .pc(pc),
    .npc(npc),
    .pc_plus8(pc_plus8),
    .in_slot(in_slot),
    .squash(squash),
    .addr_err(addr_err)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 0;
    m_npc = 4;
    m_in_delay = 0;
    m_in_slot = 0;
    m_squash = 0;
    m_addr_err = 0;
  endtask

  // Advance the model by one edge for the given inputs
  task automatic modelStep(input bit s, input bit r, input int t, input bit a);
    int old_npc;
    if (s) return;
    old_npc = m_npc;
    if (m_in_delay) begin
      m_pc = old_npc;
      m_npc = (old_npc + 4) % MOD;
      m_in_delay = 0;
      {m_in_slot, m_squash, m_addr_err} = 3'b000;
    end else if (r && (t % 4) != 0) begin
      m_pc = 256;
      m_npc = 260;
      {m_in_slot, m_squash, m_addr_err} = 3'b011;
    end else if (r) begin
      m_pc = old_npc;
      m_npc = t;
      m_in_delay = 1;
      {m_in_slot, m_squash, m_addr_err} = 3'b100;
    end else begin
      m_pc = old_npc;
      m_npc = (old_npc + 4) % MOD;
      m_in_slot = a;
      m_squash = a;
      m_addr_err = 0;
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.pc = PC_W'(m_pc);
    e.npc = PC_W'(m_npc);
    e.p8 = PC_W'((m_pc + 8) % MOD);
    e.in_slot = m_in_slot;
    e.squash = m_squash;
    e.addr_err = m_addr_err;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkValue("pc", 32'(pc), 32'(e.pc));
    checkValue("npc", 32'(npc), 32'(e.npc));
    checkValue("pc_plus8", 32'(pc_plus8), 32'(e.p8));
    checkValue("in_slot", 32'(in_slot), 32'(e.in_slot));
    checkValue("squash", 32'(squash), 32'(e.squash));
    checkValue("addr_err", 32'(addr_err), 32'(e.addr_err));
  endtask

  // Drive one cycle of inputs, predict, clock, then compare 1 time unit after the edge
  task automatic applyStimulus(input bit s, input bit r, input int t, input bit a);
    stall = s;
    redirect = r;
    target = PC_W'(t);
    annul_req = a;
    modelStep(s, r, t, a);
    pushExpected();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    target = '0;
    annul_req = 1'b0;
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_pc", 32'(pc), 32'd0);
    checkValue("reset_npc", 32'(npc), 32'd4);
    checkValue("reset_pc_plus8", 32'(pc_plus8), 32'd8);
    checkValue("reset_in_slot", 32'(in_slot), 32'd0);
    checkValue("reset_squash", 32'(squash), 32'd0);
    checkValue("reset_addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fetch 0 -> 4 -> 8
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("seq_pc8", 32'(pc), 32'd8);

    // Taken branch to 40 from pc=8
    applyStimulus(0, 1, 40, 0);
    checkValue("branch_slot_pc", 32'(pc), 32'd12);
    checkValue("branch_slot_npc", 32'(npc), 32'd40);

    // Stall in SLOT for 3 cycles, then ignored redirect to 100
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 100, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 100, 0);
    checkValue("slot_ignores_redirect", 32'(pc), 32'd40);
    applyStimulus(0, 0, 0, 0);

    // Redirect to 16 with annul_req also high; annul must be ignored
    applyStimulus(0, 1, 16, 1);
    applyStimulus(0, 0, 0, 0);
    checkValue("target16_pc", 32'(pc), 32'd16);

    // Branch-likely annul at pc=16
    applyStimulus(0, 0, 0, 1);
    checkValue("annul_squash", 32'(squash), 32'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("pre_misalign_pc", 32'(pc), 32'd32);

    // Misaligned target from pc=32, stretched by a one-cycle stall
    applyStimulus(0, 1, 42, 0);
    checkValue("exc_pc", 32'(pc), 32'd256);
    checkValue("exc_addr_err", 32'(addr_err), 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("exc_pulse_end", 32'(addr_err), 32'd0);

    // Run sequentially up to pc=508
    for (int i = 0; i < 62; i++) applyStimulus(0, 0, 0, 0);
    checkValue("wrap_pc", 32'(pc), 32'd508);
    checkValue("wrap_npc", 32'(npc), 32'd0);
    checkValue("wrap_pc_plus8", 32'(pc_plus8), 32'd4);
    applyStimulus(0, 0, 0, 0);
    checkValue("wrap_next_pc", 32'(pc), 32'd0);

    // Enter SLOT, then async reset between edges
    applyStimulus(0, 1, 40, 0);
    checkValue("pre_reset_in_slot", 32'(in_slot), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkValue("async_pc", 32'(pc), 32'd0);
    checkValue("async_npc", 32'(npc), 32'd4);
    checkValue("async_in_slot", 32'(in_slot), 32'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;

    // First edge after reset behaves as RUN: a redirect enters the delay slot
    applyStimulus(0, 1, 40, 0);
    checkValue("post_reset_slot", 32'(in_slot), 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkValue("post_reset_target", 32'(pc), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
